// File: rtl/sprite_buf_if.sv
// sprite_buf_if: groups the pixel read port, the image byte stream and the load status
// Latency: n/a (wires only)
// Backpressure: rx_ready from the slave gates rx_valid/rx_data from the master
//
// Signals:
//   pixel_addr  read address {y[5:0], x[5:0]} from the drawing stage
//   rgb_pixel   registered 4:4:4 pixel for pixel_addr, one cycle later
//   vblnk       vertical blank from the VGA timing chain (bank swap point)
//   load_start  one-cycle pulse that begins a new image load
//   rx_data     stream byte, rx_valid/rx_ready handshake
//   load_busy   load in progress (until the new image is visible)
//   swap_done   one-cycle pulse when the new image becomes visible
interface sprite_buf_if;
    logic [11:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic        vblnk;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        load_busy;
    logic        swap_done;

    modport master (
        output pixel_addr, vblnk, load_start, rx_data, rx_valid,
        input  rgb_pixel, rx_ready, load_busy, swap_done
    );

    modport slave (
        input  pixel_addr, vblnk, load_start, rx_data, rx_valid,
        output rgb_pixel, rx_ready, load_busy, swap_done
    );
endinterface

// File: rtl/sprite_buf.sv
// sprite_buf: 64x64 12-bit sprite memory; pixel reads plus byte-stream image reload
// Latency: rgb_pixel is registered, 1 cycle after pixel_addr; new image visible after swap_done
// Backpressure: rx_ready high only while loading; one byte per cycle when rx_valid is held
//
// Ports: clk40MHz (rising edge), rst (async, active high), bus (sprite_buf_if.slave).
// Build option: define SPRITE_BUF_DOUBLE_EN for two banks with a swap on the vblnk
// rising edge (tear-free). Without it a single bank is written in place and swap_done
// pulses on the last write.
module sprite_buf (
    input  logic         clk40MHz,
    input  logic         rst,
    sprite_buf_if.slave  bus
);

`ifdef SPRITE_BUF_DOUBLE_EN
    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, WAIT_SWAP} state_t;
    localparam int unsigned NWORDS = 8192;
    logic        front_sel, front_sel_nxt;
    logic        vblnk_q;
    logic [12:0] rd_idx, wr_idx;
`else
    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO} state_t;
    localparam int unsigned NWORDS = 4096;
    logic [11:0] rd_idx, wr_idx;
    logic        unused_vblnk;
`endif

    state_t      state, state_nxt;
    logic [11:0] wr_addr, wr_addr_nxt;
    logic [7:0]  hi_byte, hi_byte_nxt;
    logic        mem_we;
    logic [11:0] mem_wdat;
    logic        swap_fire;
    logic        rdy;
    logic        swap_done_r;
    logic [11:0] rgb_r;

    logic [11:0] mem [0:NWORDS-1];

`ifdef SPRITE_BUF_DOUBLE_EN
    // Bank select is the top index bit: reads from front, writes to the hidden bank.
    assign rd_idx = {front_sel, bus.pixel_addr};
    assign wr_idx = {~front_sel, wr_addr};
`else
    assign rd_idx       = bus.pixel_addr;
    assign wr_idx       = wr_addr;
    assign unused_vblnk = bus.vblnk;
`endif

    // Pixel = {R,G from first byte, B from high nibble of second byte}.
    assign mem_wdat = {hi_byte, bus.rx_data[7:4]};

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        hi_byte_nxt = hi_byte;
        mem_we      = 1'b0;
        swap_fire   = 1'b0;
        rdy         = 1'b0;
`ifdef SPRITE_BUF_DOUBLE_EN
        front_sel_nxt = front_sel;
`endif
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_nxt   = LOAD_HI;
                    wr_addr_nxt = 12'd0;
                end
            end
            LOAD_HI: begin
                rdy = 1'b1;
                if (bus.rx_valid) begin
                    hi_byte_nxt = bus.rx_data;
                    state_nxt   = LOAD_LO;
                end
            end
            LOAD_LO: begin
                rdy = 1'b1;
                if (bus.rx_valid) begin
                    mem_we = 1'b1;
                    if (wr_addr == 12'd4095) begin
`ifdef SPRITE_BUF_DOUBLE_EN
                        state_nxt = WAIT_SWAP;
`else
                        state_nxt = IDLE;
                        swap_fire = 1'b1;
`endif
                    end else begin
                        wr_addr_nxt = wr_addr + 12'd1;
                        state_nxt   = LOAD_HI;
                    end
                end
            end
`ifdef SPRITE_BUF_DOUBLE_EN
            WAIT_SWAP: begin
                // Edge-detect so a load finishing inside blank waits for the next frame.
                if (bus.vblnk && !vblnk_q) begin
                    front_sel_nxt = ~front_sel;
                    swap_fire     = 1'b1;
                    state_nxt     = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk40MHz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_addr     <= 12'd0;
            hi_byte     <= 8'd0;
            swap_done_r <= 1'b0;
            rgb_r       <= 12'h000;
`ifdef SPRITE_BUF_DOUBLE_EN
            front_sel   <= 1'b0;
            vblnk_q     <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            hi_byte     <= hi_byte_nxt;
            swap_done_r <= swap_fire;
            rgb_r       <= mem[rd_idx];
`ifdef SPRITE_BUF_DOUBLE_EN
            front_sel   <= front_sel_nxt;
            vblnk_q     <= bus.vblnk;
`endif
        end
    end

    // RAM is never reset; a partial image after reset is simply overwritten later.
    always_ff @(posedge clk40MHz) begin
        if (mem_we) begin
            mem[wr_idx] <= mem_wdat;
        end
    end

    assign bus.rgb_pixel = rgb_r;
    assign bus.rx_ready  = rdy;
    assign bus.load_busy = (state != IDLE);
    assign bus.swap_done = swap_done_r;

endmodule

// File: tb/tb_sprite_buf.sv
// tb_sprite_buf: randomized loads/reads checked every cycle against an image-level model
// Latency: model predicts rgb_pixel one cycle after pixel_addr
// Backpressure: random rx_valid gaps; sender advances only on observed handshakes
module tb_sprite_buf;

`ifdef SPRITE_BUF_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk40MHz = 1'b0;
    logic rst      = 1'b0;

    sprite_buf_if bus();

    sprite_buf dut (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk40MHz = ~clk40MHz;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int swap_cnt = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: image arrays + load progress ----------------
    logic [11:0] m_mem   [0:1][0:4095];
    bit          m_known [0:1][0:4095];
    int          m_phase = 0;   // 0 idle, 1 receiving bytes, 2 waiting for blank
    int          m_cnt   = 0;   // bytes accepted in the current load
    logic [7:0]  m_hi    = 8'h00;
    int          m_front = 0;
    logic        m_vq    = 1'b0;
    logic [11:0] m_rgb   = 12'h000;
    bit          m_rgb_known = 1'b1;
    bit          m_swap  = 1'b0;

    always @(posedge clk40MHz or posedge rst) begin : model
        int back;
        bit hs;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_front = 0; m_vq = 1'b0;
            m_rgb = 12'h000; m_rgb_known = 1'b1; m_swap = 1'b0;
        end else begin
            m_rgb       = m_mem[m_front][bus.pixel_addr];
            m_rgb_known = m_known[m_front][bus.pixel_addr];
            m_swap      = 1'b0;
            back        = DBL ? 1 - m_front : m_front;
            hs          = bus.rx_valid && (m_phase == 1);
            case (m_phase)
                0: if (bus.load_start) begin m_phase = 1; m_cnt = 0; end
                1: if (hs) begin
                    if (m_cnt % 2 == 0) m_hi = bus.rx_data;
                    else begin
                        m_mem[back][m_cnt/2]   = {m_hi, bus.rx_data[7:4]};
                        m_known[back][m_cnt/2] = 1'b1;
                    end
                    m_cnt++;
                    if (m_cnt == 8192) begin
                        if (DBL) m_phase = 2;
                        else begin m_phase = 0; m_swap = 1'b1; end
                    end
                end
                2: if (bus.vblnk && !m_vq) begin
                    m_front = 1 - m_front; m_swap = 1'b1; m_phase = 0;
                end
                default: m_phase = 0;
            endcase
            m_vq = bus.vblnk;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk40MHz) begin
        if (chk_en) begin
            chk("rx_ready",  32'(bus.rx_ready),  32'(m_phase == 1));
            chk("load_busy", 32'(bus.load_busy), 32'(m_phase != 0));
            chk("swap_done", 32'(bus.swap_done), 32'(m_swap));
            if (m_rgb_known) chk("rgb_pixel", 32'(bus.rgb_pixel), 32'(m_rgb));
            if (bus.swap_done) swap_cnt++;
        end
    end

    always @(posedge clk40MHz) begin
        if (!rst && bus.rx_valid && bus.rx_ready) hs_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk40MHz);
        #1;
    endtask

    function automatic logic [7:0] byte_for(input int kind, input int idx);
        logic [11:0] v;
        int n;
        n = idx / 2;
        case (kind)
            0:       v = 12'(n * 3);
            1:       v = 12'hF00;
            default: v = 12'(n * 7 + 5);
        endcase
        // Low nibble of the second byte is don't-care; fill with A to expose leaks.
        return (idx % 2 == 0) ? v[11:4] : {v[3:0], 4'hA};
    endfunction

    task automatic load_image(input int kind, input int vprob, input int extra_start_at,
                              input int stop_at);
        int idx;
        int budget;
        bit rdy;
        idx    = 0;
        budget = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        while (idx < stop_at && budget < 40000) begin
            bus.rx_valid   = ($urandom_range(99) < vprob);
            bus.rx_data    = byte_for(kind, idx);
            bus.pixel_addr = 12'($urandom_range(4095));
            bus.load_start = (idx == extra_start_at);
            @(negedge clk40MHz);
            rdy = bus.rx_ready;
            @(posedge clk40MHz);
            if (bus.rx_valid && rdy) idx++;
            #1;
            budget++;
        end
        bus.rx_valid   = 1'b0;
        bus.load_start = 1'b0;
        if (budget >= 40000) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_timeout: got %0d bytes expected %0d", idx, stop_at);
        end
    endtask

    task automatic vblank_pulse();
        bus.vblnk = 1'b1;
        repeat (3) tick();
        bus.vblnk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic read_px(input logic [11:0] a, input logic [11:0] exp, input string nm);
        bus.pixel_addr = a;
        tick();
        chk(nm, 32'(bus.rgb_pixel), 32'(exp));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pixel_addr = 12'd0;
        bus.vblnk      = 1'b0;
        bus.load_start = 1'b0;
        bus.rx_data    = 8'd0;
        bus.rx_valid   = 1'b0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("reset_rgb",       32'(bus.rgb_pixel), 32'h000);
        chk("reset_rx_ready",  32'(bus.rx_ready),  32'h0);
        chk("reset_load_busy", 32'(bus.load_busy), 32'h0);
        chk("reset_swap_done", 32'(bus.swap_done), 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Full load, pixel n = n*3.
        hs_cnt = 0; swap_cnt = 0;
        load_image(0, 100, -1, 8192);
        repeat (4) tick();
        chk("full_hs_count", 32'(hs_cnt), 32'd8192);
`ifdef SPRITE_BUF_DOUBLE_EN
        chk("wait_busy", 32'(bus.load_busy), 32'h1);
`endif
        vblank_pulse();
        chk("full_swap_count", 32'(swap_cnt), 32'd1);
        for (int a = 0; a < 4096; a++) begin
            bus.pixel_addr = 12'(a);
            tick();
        end
        read_px(12'd0,    12'h000, "img0_px0");
        read_px(12'd5,    12'h00F, "img0_px5");
        read_px(12'd1365, 12'hFFF, "img0_px1365");
        read_px(12'd4095, 12'hFFD, "img0_px4095");

        // Second load (all F00): the old image stays visible until the swap.
        load_image(1, 100, -1, 8192);
        repeat (2) tick();
        read_px(12'd100, DBL ? 12'h12C : 12'hF00, "no_tear_before_swap");
        vblank_pulse();
        read_px(12'd100, 12'hF00, "after_swap_px100");

        // Back-pressure with a stray load_start mid-load.
        hs_cnt = 0; swap_cnt = 0;
        load_image(2, 60, 500, 8192);
        repeat (2) tick();
        chk("bp_hs_count", 32'(hs_cnt), 32'd8192);
        vblank_pulse();
        chk("bp_swap_count", 32'(swap_cnt), 32'd1);
        read_px(12'd0,  12'h005, "bp_px0");
        read_px(12'd1,  12'h00C, "bp_px1");
        read_px(12'd10, 12'h04B, "bp_px10");
        repeat (300) begin
            bus.pixel_addr = 12'($urandom_range(4095));
            tick();
        end

        // Reset mid-load after 1000 bytes, then a fresh full load.
        load_image(0, 100, -1, 1000);
        chk("midload_rx_ready", 32'(bus.rx_ready), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rgb",       32'(bus.rgb_pixel), 32'h000);
        chk("async_rst_rx_ready",  32'(bus.rx_ready),  32'h0);
        chk("async_rst_load_busy", 32'(bus.load_busy), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        swap_cnt = 0;
        load_image(0, 100, -1, 8192);
        vblank_pulse();
        chk("fresh_swap_count", 32'(swap_cnt), 32'd1);
        read_px(12'd5,    12'h00F, "fresh_px5");
        read_px(12'd4095, 12'hFFD, "fresh_px4095");

        // Load finishing inside blank: no swap until the next vblnk rise.
        swap_cnt = 0;
        bus.vblnk = 1'b1;
        load_image(1, 100, -1, 8192);
        repeat (5) tick();
        chk("blank_swap_held", 32'(swap_cnt), DBL ? 32'd0 : 32'd1);
        read_px(12'd5, DBL ? 12'h00F : 12'hF00, "blank_old_px5");
        bus.vblnk = 1'b0;
        repeat (3) tick();
        bus.vblnk = 1'b1;
        repeat (3) tick();
        bus.vblnk = 1'b0;
        tick();
        chk("blank_swap_after", 32'(swap_cnt), 32'd1);
        read_px(12'd5, 12'hF00, "blank_new_px5");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_buf.md
# sprite_buf

Pixel-memory responder for the sprite overlay stage: answers a 12-bit `{y[5:0], x[5:0]}` pixel address with a 12-bit RGB value one clock later. It also accepts a new 64x64 sprite image as a byte stream over a valid/ready handshake. Sits between the byte source (UART receiver) and the rectangle/sprite drawing stage. It double-buffers so a reload never tears a visible frame.

## Interface
Parameters:
- none. Geometry is fixed at 64x64 pixels, 12-bit RGB (4:4:4), 4096 entries per bank.

Ports:
- `clk40MHz`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pixel_addr`  in  12  read address `{y[5:0], x[5:0]}` from the drawing stage.
- `rgb_pixel`  out  12  registered pixel data for `pixel_addr`.
- `vblnk`  in  1  vertical blank from the VGA timing chain; used for bank swap.
- `load_start`  in  1  one-cycle pulse that starts loading a new image.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  block accepts a byte this cycle.
- `load_busy`  out  1  high from an accepted `load_start` until the swap completes.
- `swap_done`  out  1  one-cycle pulse when the new image becomes visible.

## Operation
- Memory: two banks, 4096x12 each (`bank = front_sel`). Reads always come from the front bank. Writes always go to the back bank (`~front_sel`).
- Read path: `rgb_pixel <= mem[front_sel][pixel_addr]`, every cycle, independent of the FSM.
- Byte format: two bytes per pixel, high byte first.
  - byte0 = `{R[3:0], G[3:0]}`.
  - byte1 = `{B[3:0], xxxx}`; the low nibble is ignored.
  - Pixel order is raster order: address 0 to 4095, x fastest.
- FSM states: IDLE, LOAD_HI, LOAD_LO, WAIT_SWAP.
  - IDLE: `rx_ready=0`. `load_start` moves to LOAD_HI and sets `wr_addr=0`.
  - LOAD_HI: `rx_ready=1`. On `rx_valid && rx_ready`, latch `hi_byte = rx_data` and go to LOAD_LO.
  - LOAD_LO: `rx_ready=1`. On handshake, write `{hi_byte, rx_data[7:4]}` to the back bank at `wr_addr`.
    - If `wr_addr == 12'd4095`, go to WAIT_SWAP.
    - Otherwise increment `wr_addr` (12-bit) and go to LOAD_HI.
  - WAIT_SWAP: `rx_ready=0`. On a `vblnk` rising edge (`vblnk && !vblnk_q`), toggle `front_sel`, pulse `swap_done` and go to IDLE.
- `load_busy` = (state != IDLE).
- `load_start` is ignored outside IDLE.
- `rx_valid` without `rx_ready` is ignored; the byte is not consumed.
- If already inside vblank when WAIT_SWAP is entered, wait for the next rising edge. A swap never happens mid-blank.
- Reset mid-load: FSM goes to IDLE, `wr_addr=0`, `front_sel=0`, `vblnk_q=0`. RAM contents are not cleared and the partial image is discarded.

## Timing
- Read latency: exactly 1 cycle from `pixel_addr` to `rgb_pixel`. The consumer samples `rgb_pixel` one cycle after driving the address.
- Throughput: one byte per cycle when `rx_valid` is held high. A full load takes 8192 accepted bytes.
- RAM write happens at the LOAD_LO handshake edge. Data is readable from that bank after a swap.
- The `front_sel` toggle and the `swap_done` pulse occur on the same edge, one cycle after `vblnk` rises. The first read from the new bank is registered on the following edge.
- Reset values: `rgb_pixel=12'h000`, `rx_ready=0`, `load_busy=0`, `swap_done=0`.

## Configuration
- `SPRITE_BUF_DOUBLE_EN` defined: two banks and WAIT_SWAP behaviour, as described above.
- `SPRITE_BUF_DOUBLE_EN` undefined:
  - Single 4096x12 bank, no `front_sel`, WAIT_SWAP removed.
  - The last LOAD_LO handshake writes, then goes to IDLE and pulses `swap_done` on the same edge.
  - Writes are visible immediately, so tearing is possible.
  - Same-address read/write in one cycle returns the old data (read-before-write).
  - `vblnk` is unused.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `rgb_pixel=0`, `rx_ready=0`, `load_busy=0` immediately, without waiting for a clock edge.
- Full load: `load_start`, then 8192 bytes with pixel n = `12'(n*3)`, then a `vblnk` rising edge.
  - `swap_done` pulses once.
  - Sweeping `pixel_addr` 0..4095 returns `12'(n*3)` with 1-cycle latency.
- No tear: during a second load (all pixels `12'hF00`), reads keep returning the old image until the next `vblnk` rise, then return `12'hF00`.
- Back-pressure: toggle `rx_valid` randomly and pulse `load_start` mid-load.
  - The extra `load_start` is ignored.
  - Exactly 8192 handshakes occur.
  - Image correct; low nibble of byte1 = `4'hA` does not appear in the output.
- Swap while in blank: finish loading while `vblnk=1` -> no swap until `vblnk` falls and rises again.
- Reset mid-load at byte 1000, then a fresh full load -> the new image is correct and `front_sel` restarts at bank 0.
